pipelined_carry_bypass_adder: RTL and testbench

Parametrised, pipelined carry-bypass adder/subtractor for the datapath. Operands are split into BLOCK_W-bit ripple blocks, each with a propagate-driven bypass mux on its carry. A register stage is inserted after every BLOCKS_PER_STAGE blocks, so wide adds close timing at high clock rates. Operations flow through a valid/ready handshake, and the block provides add/sub mode, borrow chaining and signed overflow.

---
 rtl/cba_pkg.sv | 13 +
 rtl/pipelined_carry_bypass_adder_if.sv | 30 +++
 rtl/cba_block.sv | 32 +++
 rtl/pipelined_carry_bypass_adder.sv | 153 +++++++++++++++
 tb/tb_pipelined_carry_bypass_adder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cba_pkg.sv
// Shared defaults and helpers for the pipelined carry-bypass adder.
package cba_pkg;

  localparam int unsigned CBA_WIDTH   = 32;
  localparam int unsigned CBA_BLOCK_W = 4;
  localparam int unsigned CBA_BPS     = 2;

  // Number of block-evaluating pipeline stages (ceil division).
  function automatic int unsigned cba_lat(input int unsigned nb, input int unsigned bps);
    return (nb + bps - 1) / bps;
  endfunction

endpackage

// File: rtl/pipelined_carry_bypass_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and the adder.
interface pipelined_carry_bypass_adder_if
  import cba_pkg::*;
#(
  parameter int unsigned WIDTH = CBA_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

endinterface

// File: rtl/cba_block.sv
// One BLOCK_W-bit ripple block whose carry-out bypasses the ripple chain
// when every bit propagates.
module cba_block
  import cba_pkg::*;
#(
  parameter int unsigned BLOCK_W = CBA_BLOCK_W
) (
  input  logic [BLOCK_W-1:0] i_a,
  input  logic [BLOCK_W-1:0] i_b,
  input  logic               i_cin,
  output logic [BLOCK_W-1:0] o_sum,
  output logic               o_p,
  output logic               o_cout
);

  logic [BLOCK_W:0] w_rc;

  // Ripple chain through the block.
  always_comb begin
    w_rc    = '0;
    o_sum   = '0;
    w_rc[0] = i_cin;
    for (int i = 0; i < int'(BLOCK_W); i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_rc[i];
      w_rc[i+1] = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & w_rc[i]);
    end
  end

  assign o_p    = &(i_a ^ i_b);
  assign o_cout = o_p ? i_cin : w_rc[BLOCK_W];

endmodule

// File: rtl/pipelined_carry_bypass_adder.sv
// Pipelined carry-bypass adder/subtractor: BLOCKS_PER_STAGE blocks per register
// stage, whole-pipeline valid/ready stall, registered sum/cout/overflow.
module pipelined_carry_bypass_adder
  import cba_pkg::*;
#(
  parameter int unsigned WIDTH            = CBA_WIDTH,
  parameter int unsigned BLOCK_W          = CBA_BLOCK_W,
  parameter int unsigned BLOCKS_PER_STAGE = CBA_BPS
) (
  input logic                          clk,
  input logic                          rst_n,
  pipelined_carry_bypass_adder_if.slave bus
);

  localparam int unsigned NB  = WIDTH / BLOCK_W;
  localparam int unsigned BPS = BLOCKS_PER_STAGE;
  localparam int unsigned LAT = cba_lat(NB, BPS);
  localparam int unsigned MSB = WIDTH - 1;

  logic                          w_advance;
  logic [WIDTH-1:0]              w_b_eff;
  logic                          w_c0;

  // Per-stage inputs: stage 0 reads the bus, stage k reads register stage k-1.
  logic                          w_v_src   [LAT];
  logic [WIDTH-1:0]              w_a_src   [LAT];
  logic [WIDTH-1:0]              w_b_src   [LAT];
  logic                          w_c_src   [LAT];
  logic [WIDTH-1:0]              w_sum_src [LAT];
  logic [WIDTH-1:0]              w_sum_nxt [LAT];
  logic [LAT-1:0]                w_c_nxt;

  logic [NB-1:0][BLOCK_W-1:0]    w_blk_sum;
  logic [NB-1:0]                 w_blk_p;
  logic [NB-1:0]                 w_blk_cout;

  logic                          r_v   [LAT];
  logic [WIDTH-1:0]              r_a   [LAT];
  logic [WIDTH-1:0]              r_b   [LAT];
  logic                          r_c   [LAT];
  logic [WIDTH-1:0]              r_sum [LAT];

  logic                          r_out_valid;
  logic [WIDTH-1:0]              r_res_sum;
  logic                          r_res_cout;
  logic                          r_res_ovf;

  assign w_advance = !r_out_valid || bus.out_ready;
  assign w_b_eff   = bus.sub ? ~bus.b : bus.b;
  assign w_c0      = bus.sub ^ bus.cin;

  // Route each stage's source operands.
  always_comb begin
    w_v_src[0]   = bus.in_valid;
    w_a_src[0]   = bus.a;
    w_b_src[0]   = w_b_eff;
    w_c_src[0]   = w_c0;
    w_sum_src[0] = '0;
    for (int k = 1; k < int'(LAT); k++) begin
      w_v_src[k]   = r_v[k-1];
      w_a_src[k]   = r_a[k-1];
      w_b_src[k]   = r_b[k-1];
      w_c_src[k]   = r_c[k-1];
      w_sum_src[k] = r_sum[k-1];
    end
  end

  for (genvar j = 0; j < int'(NB); j++) begin : g_blk
    localparam int unsigned STG = j / BPS;
    logic w_cin;
    if (j % BPS == 0) begin : g_head
      assign w_cin = w_c_src[STG];
    end else begin : g_body
      assign w_cin = w_blk_cout[j-1];
    end
    cba_block #(.BLOCK_W(BLOCK_W)) u_blk (
      .i_a    (w_a_src[STG][j*BLOCK_W +: BLOCK_W]),
      .i_b    (w_b_src[STG][j*BLOCK_W +: BLOCK_W]),
      .i_cin  (w_cin),
      .o_sum  (w_blk_sum[j]),
      .o_p    (w_blk_p[j]),
      .o_cout (w_blk_cout[j])
    );
  end

  // A fully propagating stage passes its incoming carry straight through.
  for (genvar k = 0; k < int'(LAT); k++) begin : g_stg
    localparam int unsigned FIRST = k * BPS;
    localparam int unsigned LAST  = ((k + 1) * BPS > NB) ? NB - 1 : (k + 1) * BPS - 1;
    assign w_c_nxt[k] = (&w_blk_p[LAST:FIRST]) ? w_c_src[k] : w_blk_cout[LAST];
  end

  // Merge each stage's freshly computed blocks into the partial sum.
  always_comb begin
    for (int k = 0; k < int'(LAT); k++) begin
      w_sum_nxt[k] = w_sum_src[k];
      for (int j = 0; j < int'(NB); j++) begin
        w_sum_nxt[k][j*BLOCK_W +: BLOCK_W] = (j / BPS == k) ? w_blk_sum[j]
                                                            : w_sum_nxt[k][j*BLOCK_W +: BLOCK_W];
      end
    end
  end

  // Stage registers: the whole pipeline shifts together or holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(LAT); k++) begin
        r_v[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_c[k]   <= 1'b0;
        r_sum[k] <= '0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < int'(LAT); k++) begin
        r_v[k]   <= w_v_src[k];
        r_a[k]   <= w_a_src[k];
        r_b[k]   <= w_b_src[k];
        r_c[k]   <= w_c_nxt[k];
        r_sum[k] <= w_sum_nxt[k];
      end
    end
  end

  // Output registers; result data only loads on a valid op so bubbles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_cout  <= 1'b0;
      r_res_ovf   <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_v[LAT-1];
      if (r_v[LAT-1]) begin
        r_res_sum  <= r_sum[LAT-1];
        r_res_cout <= r_c[LAT-1];
        r_res_ovf  <= (r_a[LAT-1][MSB] == r_b[LAT-1][MSB]) &&
                      (r_sum[LAT-1][MSB] != r_a[LAT-1][MSB]);
      end else begin
        r_res_sum  <= r_res_sum;
        r_res_cout <= r_res_cout;
        r_res_ovf  <= r_res_ovf;
      end
    end
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_res_sum;
  assign bus.cout      = r_res_cout;
  assign bus.overflow  = r_res_ovf;

endmodule

// File: tb/tb_pipelined_carry_bypass_adder.sv
// Randomised and directed bench for pipelined_carry_bypass_adder against an
// arithmetic reference model with an in-order scoreboard.
module tb_pipelined_carry_bypass_adder;
  import cba_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned BLOCK_W = 4;
  localparam int unsigned BPS     = 2;
  localparam int unsigned LAT     = cba_lat(WIDTH / BLOCK_W, BPS);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_carry_bypass_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_carry_bypass_adder #(
    .WIDTH(WIDTH), .BLOCK_W(BLOCK_W), .BLOCKS_PER_STAGE(BPS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          n_out    = 0;
  bit          lat_flag = 1'b0;
  bit          held     = 1'b0;
  logic [31:0] held_sum;
  logic        held_cout, held_ovf;
  logic [31:0] last_sum;
  logic        last_cout, last_ovf;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer arithmetic, no bit-level carry logic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t                  e;
    longint                sa, sb, r;
    longint unsigned       ua, ub, u;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (!sub) begin
      u      = ua + ub + {63'd0, cin};
      r      = sa + sb + {63'd0, cin};
      e.cout = (u >= 64'h1_0000_0000);
    end else begin
      u      = ua - ub - {63'd0, cin};
      r      = sa - sb - {63'd0, cin};
      e.cout = (ua >= ub + {63'd0, cin});
    end
    e.sum     = u[31:0];
    e.ovf     = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.acc_cyc = 0;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub, input logic ordy);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.sub       = sub;
    bus.out_ready = ordy;
  endtask

  // Sample handshakes just after the falling edge, then advance one cycle.
  task automatic step();
    exp_t e;
    #1;
    if (held) begin
      check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_sum",   64'(bus.sum),       64'(held_sum));
      check_eq("hold_cout",  64'(bus.cout),      64'(held_cout));
      check_eq("hold_ovf",   64'(bus.overflow),  64'(held_ovf));
    end
    held      = bus.out_valid && !bus.out_ready;
    held_sum  = bus.sum;
    held_cout = bus.cout;
    held_ovf  = bus.overflow;
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      last_sum  = bus.sum;
      last_cout = bus.cout;
      last_ovf  = bus.overflow;
      if (sbq.size() == 0) begin
        check_eq("out_with_empty_sb", 64'(sbq.size()), 64'd1);
      end else begin
        e = sbq.pop_front();
        check_eq("sum",      64'(bus.sum),      64'(e.sum));
        check_eq("cout",     64'(bus.cout),     64'(e.cout));
        check_eq("overflow", 64'(bus.overflow), 64'(e.ovf));
        if (e.chk_lat) check_eq("latency", 64'(cyc - e.acc_cyc - 1), 64'(LAT));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      e         = model(bus.a, bus.b, bus.cin, bus.sub);
      e.acc_cyc = cyc;
      e.chk_lat = lat_flag;
      sbq.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub,
                         input logic [31:0] x_sum, input logic x_cout, input logic x_ovf);
    drive(1'b1, a, b, cin, sub, 1'b1);
    step();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20 && sbq.size() != 0; k++) step();
    check_eq({tag, "_drained"}, 64'(sbq.size()), 64'd0);
    check_eq({tag, "_sum"},  64'(last_sum),  64'(x_sum));
    check_eq({tag, "_cout"}, 64'(last_cout), 64'(x_cout));
    check_eq({tag, "_ovf"},  64'(last_ovf),  64'(x_ovf));
  endtask

  logic [31:0] a5 [8];
  logic [31:0] b5 [8];
  logic        c5 [8];
  logic        s5 [8];
  int          idx, out_base, s;
  bit          stall, acc;
  logic [31:0] ra;
  logic        rsub;

  initial begin
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);

    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_sum",       64'(bus.sum),       64'd0);
      check_eq("rst_cout",      64'(bus.cout),      64'd0);
      check_eq("rst_ovf",       64'(bus.overflow),  64'd0);
    end
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);

    // Directed arithmetic with latency checking.
    lat_flag = 1'b1;
    run_one("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("add_byp",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_one("sub_neg",  32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    run_one("sub_bin",  32'd10,        32'd3,         1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0);
    lat_flag = 1'b0;

    // Eight back-to-back ops with a three-cycle consumer stall mid-stream.
    for (int i = 0; i < 8; i++) begin
      a5[i] = $urandom;
      b5[i] = $urandom;
      c5[i] = 1'($urandom_range(0, 1));
      s5[i] = 1'($urandom_range(0, 1));
    end
    idx      = 0;
    out_base = n_out;
    for (s = 0; s < 60 && (idx < 8 || sbq.size() != 0); s++) begin
      stall = (s >= 6 && s <= 8);
      if (idx < 8) drive(1'b1, a5[idx], b5[idx], c5[idx], s5[idx], !stall);
      else         drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, !stall);
      #1;
      check_eq("stream_in_ready", 64'(bus.in_ready), 64'(!stall));
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) idx++;
    end
    check_eq("stream_count", 64'(n_out - out_base), 64'd8);

    // Random traffic with random back-pressure and frequent full-propagate operands.
    for (int i = 0; i < 80; i++) begin
      ra   = $urandom;
      rsub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        drive(1'($urandom_range(0, 1)), ra, rsub ? ra : ~ra, 1'($urandom_range(0, 1)), rsub,
              1'($urandom_range(0, 1)));
      else
        drive(1'($urandom_range(0, 1)), ra, $urandom, 1'($urandom_range(0, 1)), rsub,
              1'($urandom_range(0, 1)));
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20 && sbq.size() != 0; k++) step();
    check_eq("random_drained", 64'(sbq.size()), 64'd0);

    // Reset pulse with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
      step();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check_eq("inflight_before_rst", 64'(sbq.size()), 64'd3);
    rst_n = 1'b0;
    #1;
    check_eq("rst_pulse_out_valid", 64'(bus.out_valid), 64'd0);
    sbq.delete();
    held = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      #1;
      check_eq("no_stale_out", 64'(bus.out_valid), 64'd0);
      step();
    end
    lat_flag = 1'b1;
    run_one("post_rst", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
